// File: rtl/audio_clk_rst_seq.sv
// Lock qualification, datapath reset sequencing and codec clock generation
// for the audio PLL domain. All outputs come straight from registers.
module audio_clk_rst_seq #(
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned RST_HOLD  = 256,
  parameter int unsigned BCLK_DIV  = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       reset_out,
  output logic       bclk,
  output logic       lrclk,
  output logic       bclk_fall_stb,
  output logic       frame_stb,
  output logic [1:0] state_o,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned QW = $clog2(LOCK_WAIT);
  localparam int unsigned HW = (RST_HOLD  > 1) ? $clog2(RST_HOLD)  : 1;
  localparam int unsigned DW = (BCLK_DIV  > 1) ? $clog2(BCLK_DIV)  : 1;
  localparam int unsigned BW = $clog2(2 * SLOT_BITS);

  localparam logic [QW-1:0] QLAST = QW'(LOCK_WAIT - 1);
  localparam logic [HW-1:0] HLAST = HW'(RST_HOLD - 1);
  localparam logic [DW-1:0] DLAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT  = BW'(SLOT_BITS);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d, bit_nxt;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          fall_q, fall_d;
  logic          frame_q, frame_d;
  logic          rsto_q, rsto_d;
  logic [7:0]    lost_q, lost_d;

  // Two-FF synchronizer; sync_q[1] is the only consumer-visible lock.
  assign locked_s = sync_q[1];
  assign bit_nxt  = (bitcnt_q == BLAST) ? '0 : bitcnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    hcnt_d   = hcnt_q;
    dcnt_d   = dcnt_q;
    bitcnt_d = bitcnt_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    fall_d   = 1'b0;
    frame_d  = 1'b0;
    lost_d   = lost_q;

    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = QUALIFY;
          qcnt_d  = '0;
        end
      end
      QUALIFY: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (qcnt_q == QLAST) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (hcnt_q == HLAST) begin
          state_d = RUN;
          frame_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (lost_q != 8'hFF) lost_d = lost_q + 1'b1;
        end else if (dcnt_q == DLAST) begin
          dcnt_d = '0;
          bclk_d = ~bclk_q;
          // Falling edge: advance the bit slot and derive word select from it.
          if (bclk_q) begin
            fall_d   = 1'b1;
            bitcnt_d = bit_nxt;
            lrclk_d  = (bit_nxt >= SLOT);
            frame_d  = (bit_nxt == '0);
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Any state other than RUN keeps the clock generator parked at its origin.
    if (state_d != RUN) begin
      dcnt_d   = '0;
      bitcnt_d = '0;
      bclk_d   = 1'b0;
      lrclk_d  = 1'b0;
      fall_d   = 1'b0;
      frame_d  = 1'b0;
    end
    if (state_d == WAIT_LOCK) begin
      qcnt_d = '0;
      hcnt_d = '0;
    end
    rsto_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= WAIT_LOCK;
      qcnt_q   <= '0;
      hcnt_q   <= '0;
      dcnt_q   <= '0;
      bitcnt_q <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      fall_q   <= 1'b0;
      frame_q  <= 1'b0;
      rsto_q   <= 1'b1;
      lost_q   <= '0;
    end else begin
      sync_q   <= {sync_q[0], pll_locked};
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      hcnt_q   <= hcnt_d;
      dcnt_q   <= dcnt_d;
      bitcnt_q <= bitcnt_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      fall_q   <= fall_d;
      frame_q  <= frame_d;
      rsto_q   <= rsto_d;
      lost_q   <= lost_d;
    end
  end

  assign reset_out     = rsto_q;
  assign bclk          = bclk_q;
  assign lrclk         = lrclk_q;
  assign bclk_fall_stb = fall_q;
  assign frame_stb     = frame_q;
  assign state_o       = state_q;
  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_audio_clk_rst_seq.sv
// Scoreboard bench for audio_clk_rst_seq: a lock-streak reference model queues
// expected outputs each edge; a monitor pops and compares on the falling edge.
module tb_audio_clk_rst_seq;
  localparam int LW = 16;
  localparam int RH = 8;
  localparam int D  = 2;
  localparam int S  = 4;

  logic       clk, rst, pll_locked;
  logic       reset_out, bclk, lrclk, bclk_fall_stb, frame_stb;
  logic [1:0] state_o;
  logic [7:0] lock_lost_cnt;

  audio_clk_rst_seq #(.LOCK_WAIT(LW), .RST_HOLD(RH), .BCLK_DIV(D), .SLOT_BITS(S)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .reset_out(reset_out), .bclk(bclk), .lrclk(lrclk),
    .bclk_fall_stb(bclk_fall_stb), .frame_stb(frame_stb),
    .state_o(state_o), .lock_lost_cnt(lock_lost_cnt)
  );

  typedef struct packed {
    logic       rsto;
    logic       bclk;
    logic       lrclk;
    logic       fall;
    logic       frame;
    logic [1:0] st;
    logic [7:0] lost;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_streak = 0;
  int   m_lost = 0;
  bit   m_s1 = 0, m_s2 = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: state follows from how many consecutive edges saw lock;
  // clock outputs follow from cycles elapsed in RUN.
  initial begin
    obs_t e;
    bit   ls;
    int   run;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = 0; m_s2 = 0; m_streak = 0; m_lost = 0;
      end else begin
        ls = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
        if (ls) m_streak++;
        else begin
          if (m_streak > LW + RH) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          m_streak = 0;
        end
      end
      e = '0;
      e.rsto = 1'b1;
      if (m_streak == 0)            e.st = 2'd0;
      else if (m_streak <= LW)      e.st = 2'd1;
      else if (m_streak <= LW + RH) e.st = 2'd2;
      else begin
        run     = m_streak - (LW + RH + 1);
        e.st    = 2'd3;
        e.rsto  = 1'b0;
        e.bclk  = ((run / D) % 2) == 1;
        e.fall  = (run > 0) && (run % (2 * D) == 0);
        e.lrclk = ((run / (2 * D)) % (2 * S)) >= S;
        e.frame = (run % (4 * D * S)) == 0;
      end
      e.lost = m_lost[7:0];
      exp_q.push_back(e);
    end
  end

  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      a = {reset_out, bclk, lrclk, bclk_fall_stb, frame_stb, state_o, lock_lost_cnt};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t: no expectation for observed %h", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e)
          begin
            n_fail++;
            $display("FAIL outputs t=%0t: got rsto=%b bclk=%b lr=%b fall=%b frame=%b st=%0d lost=%0d, expected rsto=%b bclk=%b lr=%b fall=%b frame=%b st=%0d lost=%0d",
                     $time, a.rsto, a.bclk, a.lrclk, a.fall, a.frame, a.st, a.lost,
                     e.rsto, e.bclk, e.lrclk, e.fall, e.frame, e.st, e.lost);
          end
      end
    end
  end

  task automatic check(input string nm, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, got, expv);
    end
  endtask

  initial begin
    int target;
    bit hit;
    rst = 1; pll_locked = 0;
    repeat (5) @(negedge clk);
    check("rst_reset_out", reset_out, 1);
    check("rst_state", state_o, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    check("idle_state", state_o, 0);
    check("idle_bclk", bclk, 0);

    // Glitch at qcnt=10, then the re-rise is the edge e for timing checks.
    pll_locked = 1;
    repeat (12) @(negedge clk);
    pll_locked = 0;
    @(negedge clk);
    pll_locked = 1;
    repeat (2) @(negedge clk);
    check("glitch_wait", state_o, 0);
    @(negedge clk);
    check("qual_e2", state_o, 1);
    repeat (15) @(negedge clk);
    check("qual_e17", state_o, 1);
    @(negedge clk);
    check("hold_e18", state_o, 2);
    repeat (7) @(negedge clk);
    check("hold_e25", state_o, 2);
    check("hold_reset_out", reset_out, 1);
    @(negedge clk);
    check("run_e26", state_o, 3);
    check("run_reset_out", reset_out, 0);
    check("run_frame_T", frame_stb, 1);
    check("glitch_lost", lock_lost_cnt, 0);
    repeat (140) @(negedge clk);

    // Loss mid-frame then relock.
    repeat ($urandom_range(5, 25)) @(negedge clk);
    pll_locked = 0;
    repeat (3) @(negedge clk);
    check("loss_state", state_o, 0);
    check("loss_reset_out", reset_out, 1);
    check("loss_bclk", bclk, 0);
    check("loss_lrclk", lrclk, 0);
    check("loss_cnt", lock_lost_cnt, 1);
    repeat (5) @(negedge clk);
    pll_locked = 1;
    repeat (27) @(negedge clk);
    check("relock_frame", frame_stb, 1);
    check("relock_state", state_o, 3);
    repeat (40) @(negedge clk);

    // Random lock toggling with occasional synchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) pll_locked = ~pll_locked;
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 0;
    pll_locked = 0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 260; i++) begin
      pll_locked = 1;
      repeat (27 + $urandom_range(0, 12)) @(negedge clk);
      pll_locked = 0;
      repeat (4) @(negedge clk);
    end
    check("sat_cnt", lock_lost_cnt, 255);

    // Synchronous reset while bclk=1 and lrclk=1.
    pll_locked = 1;
    target = LW + RH + 1 + 18;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_streak == target) begin hit = 1; break; end
    end
    check("rstrun_reached", hit, 1);
    check("rstrun_bclk_pre", bclk, 1);
    check("rstrun_lrclk_pre", lrclk, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstrun_state", state_o, 0);
    check("rstrun_reset_out", reset_out, 1);
    check("rstrun_bclk", bclk, 0);
    check("rstrun_lrclk", lrclk, 0);
    check("rstrun_lost", lock_lost_cnt, 0);
    repeat (40) @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_clk_rst_seq.md
Name: audio_clk_rst_seq

Overview:
- Sits directly downstream of the audio PLL. Runs on the PLL's 10 MHz output and consumes its `locked` signal.
- Qualifies lock and sequences a synchronous reset for the audio datapath.
- Once running, generates the codec serial clocks (bclk, lrclk) plus one-cycle strobes that the serializer and sample FIFO use.
- On loss of lock, drops back into reset and silences the clocks.

Parameters:
- LOCK_WAIT, 1024: consecutive clk cycles of synchronized lock required before leaving QUALIFY (≥2).
- RST_HOLD, 256: clk cycles reset_out stays asserted after qualification (≥1).
- BCLK_DIV, 4: clk cycles per bclk half-period (≥1); bclk = clk/(2*BCLK_DIV).
- SLOT_BITS, 32: bclk periods per channel slot; frame = 2*SLOT_BITS bclk periods.

Ports:
- clk  in  1  audio-domain clock (PLL 10 MHz output)
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  raw PLL lock; asynchronous to clk
- reset_out  out  1  synchronous active-high reset to audio datapath
- bclk  out  1  codec bit clock
- lrclk  out  1  codec word select; 0 = left slot, 1 = right slot
- bclk_fall_stb  out  1  1-cycle pulse, coincident with bclk going 1→0
- frame_stb  out  1  1-cycle pulse marking frame start (left slot, bit 0)
- state_o  out  2  current state: 0 WAIT_LOCK, 1 QUALIFY, 2 HOLD, 3 RUN
- lock_lost_cnt  out  8  count of RUN→WAIT_LOCK exits, saturating at 255

Behaviour:
- Lock synchronization: pll_locked passes through a 2-FF synchronizer to give locked_s. No other logic uses pll_locked directly.
- rst (any state, any cycle) sets:
  - state = WAIT_LOCK; sync FFs = 0; all counters = 0; lock_lost_cnt = 0
  - reset_out = 1; bclk = 0; lrclk = 0; all strobes = 0
- All outputs are registered.
- WAIT_LOCK: go to QUALIFY when locked_s = 1, clearing qcnt = 0.
- QUALIFY:
  - qcnt increments every cycle.
  - When qcnt == LOCK_WAIT-1 and locked_s = 1, go to HOLD with hcnt = 0.
- HOLD:
  - hcnt increments every cycle.
  - When hcnt == RST_HOLD-1, go to RUN.
- Cycle accounting: if pll_locked is sampled high at edge e, the state register reads RUN after edge e+2+LOCK_WAIT+RST_HOLD.
- Lock drop: locked_s = 0 in QUALIFY, HOLD or RUN → WAIT_LOCK on the next edge. That same edge sets reset_out = 1, bclk = 0, lrclk = 0, clears the counters and kills the strobes.
  - lock_lost_cnt increments only when the exit is from RUN.
  - Once 255, it holds.
- reset_out = 1 in WAIT_LOCK, QUALIFY and HOLD; reset_out = 0 only in RUN. It deasserts on the same edge state becomes RUN.
- RUN clock generation (T = first cycle state == RUN):
  - At T: dcnt = 0, bitcnt = 0, bclk = 0, lrclk = 0, frame_stb = 1 for cycle T only.
  - dcnt counts 0..BCLK_DIV-1 and wraps. At dcnt == BCLK_DIV-1, bclk toggles on the next edge.
  - First bclk rise at T+BCLK_DIV; first fall at T+2*BCLK_DIV.
  - bclk_fall_stb is registered together with bclk, so it is high exactly during the cycle bclk first reads 0 after being 1.
  - Each falling edge advances bitcnt (0..2*SLOT_BITS-1, wrapping to 0). lrclk is updated in the same register stage: lrclk = (next bitcnt ≥ SLOT_BITS).
  - When bitcnt wraps to 0, frame_stb pulses coincident with that bclk_fall_stb, and lrclk returns to 0.
- BCLK_DIV = 1: bclk toggles every cycle; bclk_fall_stb is high every second cycle.
- No glitches: bclk and lrclk change only via their registers. There is no combinational gating of clk.

Test Plan:
Bench parameters: LOCK_WAIT=16, RST_HOLD=8, BCLK_DIV=2, SLOT_BITS=4.
- Reset/idle: rst high 5 cycles with pll_locked=0 → reset_out=1, bclk=0, lrclk=0, state_o=0, lock_lost_cnt=0; holds indefinitely after rst drops.
- Clean lock: pll_locked rises, first sampled at edge e
  - → state_o=1 after e+2, 2 after e+18, 3 after e+26
  - → reset_out falls after e+26
  - → frame_stb 1 cycle at T; bclk period 4 cycles, first rise at T+2
  - → lrclk rises at the 4th bclk fall and falls at the 8th, which coincides with frame_stb.
- Lock glitch in QUALIFY: pll_locked low for 1 cycle at qcnt=10 → return to WAIT_LOCK; full 16-cycle requalification required afterwards; lock_lost_cnt stays 0.
- Lock loss in RUN: drop pll_locked mid-frame
  - → 3 edges later state_o=0, reset_out=1, bclk=0, lrclk=0; lock_lost_cnt=1
  - → relock restarts the frame at bitcnt 0 with frame_stb.
- Saturation: 260 RUN→lock-loss cycles → lock_lost_cnt reads 255.
- Sync reset mid-RUN: rst asserted for 1 cycle while bclk=1, lrclk=1 → next cycle all outputs at reset values; lock_lost_cnt=0; state_o=0.
